// File: rtl/booth_arbiter_if.sv
// Requester, response and multiplier-side signals of booth_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface booth_arbiter_if #(
    parameter int N = 8
);
    logic                  req0_valid;
    logic signed [N-1:0]   req0_m;
    logic signed [N-1:0]   req0_q;
    logic                  req0_ready;
    logic                  req1_valid;
    logic signed [N-1:0]   req1_m;
    logic signed [N-1:0]   req1_q;
    logic                  req1_ready;
    logic                  resp_valid;
    logic                  resp_id;
    logic signed [2*N-1:0] resp_p;
    logic                  resp_ready;
    logic                  booth_rst;
    logic signed [N-1:0]   booth_m;
    logic signed [N-1:0]   booth_q;
    logic signed [2*N-1:0] booth_p;

    modport slave (
        input  req0_valid, req0_m, req0_q,
        output req0_ready,
        input  req1_valid, req1_m, req1_q,
        output req1_ready,
        output resp_valid, resp_id, resp_p,
        input  resp_ready,
        output booth_rst, booth_m, booth_q,
        input  booth_p
    );

    modport master (
        output req0_valid, req0_m, req0_q,
        input  req0_ready,
        output req1_valid, req1_m, req1_q,
        input  req1_ready,
        input  resp_valid, resp_id, resp_p,
        output resp_ready,
        input  booth_rst, booth_m, booth_q,
        output booth_p
    );
endinterface

// File: rtl/booth_arbiter.sv
// Round-robin front end for a shared sequential Booth multiplier: grants one of two
// requesters, sequences load/compute/capture and returns the product with its owner ID.
module booth_arbiter #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    booth_arbiter_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  last_id_q;
    logic                  resp_valid_q;
    logic                  resp_id_q;
    logic signed [2*N-1:0] p_q;
    logic                  booth_rst_q;
    logic signed [N-1:0]   m_q;
    logic signed [N-1:0]   q_q;

    logic                  gnt0_d;
    logic                  gnt1_d;
    logic                  rdy0_d;
    logic                  rdy1_d;

    // Under contention the requester that did not win last time is granted.
    always_comb begin
        gnt0_d = bus.req0_valid && (!bus.req1_valid || last_id_q);
        gnt1_d = bus.req1_valid && (!bus.req0_valid || !last_id_q);
        rdy0_d = !rst && (state_q == IDLE) && gnt0_d;
        rdy1_d = !rst && (state_q == IDLE) && gnt1_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_id_q    <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            p_q          <= '0;
            booth_rst_q  <= 1'b1;
            m_q          <= '0;
            q_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rdy0_d) begin
                        m_q       <= bus.req0_m;
                        q_q       <= bus.req0_q;
                        resp_id_q <= 1'b0;
                        last_id_q <= 1'b0;
                        state_q   <= LOAD;
                    end else if (rdy1_d) begin
                        m_q       <= bus.req1_m;
                        q_q       <= bus.req1_q;
                        resp_id_q <= 1'b1;
                        last_id_q <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q       <= '0;
                    booth_rst_q <= 1'b0;
                    state_q     <= RUN;
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        booth_rst_q <= 1'b1;
                        state_q     <= CAPT;
                    end
                end
                CAPT: begin
                    // booth_p here reflects the N-th compute edge.
                    p_q          <= bus.booth_p;
                    resp_valid_q <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = rdy0_d;
    assign bus.req1_ready = rdy1_d;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_p     = p_q;
    assign bus.booth_rst  = booth_rst_q;
    assign bus.booth_m    = m_q;
    assign bus.booth_q    = q_q;
endmodule

// File: doc/booth_arbiter.md
# booth_arbiter

Two-port arbiter and sequencer for the shared sequential `Booth #(N)` multiplier. It accepts signed N-bit operand pairs from two requesters over valid/ready handshakes and grants them in round-robin order. It drives the multiplier's load/reset, counts the N compute cycles, captures the 2N-bit product and returns it with the requester ID. Its `booth_*` ports connect one-to-one to the multiplier instance (`clk`, `rst`, `m`, `q`, `P`).

## Interface
- `N`, 8, operand width; must match the attached `Booth` instance; N ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_m`, `req0_q`  in  N each  requester 0 multiplicand and multiplier, two's complement.
- `req0_ready`  out  1  requester 0 operands accepted this cycle.
- `req1_valid`, `req1_m`, `req1_q`, `req1_ready`: same as the port-0 signals, for requester 1.
- `resp_valid`  out  1  product available.
- `resp_id`  out  1  requester that owns the product.
- `resp_p`  out  2N  signed product.
- `resp_ready`  in  1  consumer takes the product.
- `booth_rst`  out  1  multiplier load/reset; high = load `booth_m`/`booth_q`.
- `booth_m`, `booth_q`  out  N each  registered operands to the multiplier.
- `booth_p`  in  2N  multiplier product output.

## Operation
States: IDLE, LOAD, RUN, CAPT, DONE.

- **IDLE**
  - `reqX_ready = (state==IDLE) && grant==X`; ready is combinational.
  - Grant rule: if only one requester is valid, it is granted. If both are valid, the requester other than `last_id` is granted.
  - On a handshake (`reqX_valid && reqX_ready`): latch the operands into `booth_m`/`booth_q`, latch X into `resp_id`, set `last_id<=X`, go to LOAD.
- **LOAD**: `booth_rst=1` for exactly one cycle. Then `cnt<=0` and go to RUN.
- **RUN**
  - `booth_rst=0`.
  - `cnt` increments on each edge.
  - After N RUN cycles (edge where `cnt==N-1`), go to CAPT.
- **CAPT**
  - `booth_rst=1`.
  - At the end of the cycle, `resp_p<=booth_p`, which is the value produced by the N-th compute edge. Go to DONE.
- **DONE**
  - `resp_valid=1` and `booth_rst=1`. `resp_p` and `resp_id` hold stable.
  - The edge with `resp_ready=1` returns to IDLE.
- `booth_rst` is low only in RUN. The multiplier is held in load at all other times.
- `cnt` width is `$clog2(N+1)`. No wrap occurs within one operation.
- Operand registers change only on a handshake edge.
- This block performs no arithmetic. `resp_p` is exactly the captured `booth_p`; sign handling belongs to the multiplier.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `last_id` 1 (so requester 0 wins the first contention).
  - `resp_valid` 0, `resp_id` 0, `resp_p` 0.
  - `booth_rst` 1, `booth_m` 0, `booth_q` 0.
  - `req0_ready` and `req1_ready` 0 while `rst` is high.
- Latency, with handshake in cycle 0:
  - LOAD in cycle 1.
  - RUN in cycles 2..N+1.
  - CAPT in cycle N+2.
  - `resp_valid` first high in cycle N+3 (cycle 11 for N=8).
- Throughput: at most one operation per N+4 cycles with `resp_ready` held high. Only one operation is in flight.
- Backpressure: `resp_ready` low holds DONE indefinitely. No new request is accepted until the return to IDLE.
- A request arriving in DONE while `resp_ready=1` is not accepted that cycle. It becomes ready in the next (IDLE) cycle.
- Requesters hold `valid` and operands until ready. Deasserting valid before ready is legal and leaves no side effect.
- Reset mid-operation (any state): return to IDLE next edge, with all outputs at their reset values and the product discarded.
- Both `valid` high every cycle: grants alternate 0,1,0,1 starting with 0 after reset.

## Test plan
- **Single request, requester 0:** `m=125`, `q=38`, `resp_ready=1` → `resp_valid` in cycle 11 after handshake; `resp_p=16'h128E` (4750); `resp_id=0`; `booth_rst` low exactly 8 cycles.
- **Single request, requester 1:** `m=-95` (`8'hA1`), `q=38` → `resp_p=16'hF1E6` (-3610); `resp_id=1`; `req0_ready` stays 0 throughout.
- **Contention:** both requesters valid continuously with distinct operands → grant order 0,1,0,1. Each product is correct and tagged with the right `resp_id`. Operations are spaced 12 cycles apart.
- **Backpressure:** `resp_ready=0` for 20 cycles after `resp_valid` → `resp_p` and `resp_id` stable, `reqX_ready` 0, `booth_rst` 1. Raising `resp_ready` → IDLE next cycle.
- **Reset in RUN:** assert `rst` in RUN at `cnt=3` → next cycle state IDLE, `resp_valid=0`, `booth_rst=1`. A fresh 125×38 request then completes correctly.
- **Edge operands:** `m=8'h80`, `q=8'h80` → `16'h4000`; `m=8'h80`, `q=8'h7F` → `16'hC080`; `m=0`, `q=8'hFF` → `16'h0000`.
